// File: rtl/debug_ram_loader.sv
// Load/run/dump engine: writes an input word stream into a BRAM debug port, runs the core
// for a fixed window, then streams the whole BRAM back out.
module debug_ram_loader #(
  parameter int unsigned BRAMWORDS  = 4096,
  parameter int unsigned RUN_CYCLES = 200000,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] Debug_RAM_A2,
  output logic [31:0] Debug_RAM_WD2,
  output logic [3:0]  Debug_RAM_WE2,
  input  logic [31:0] Debug_RAM_RD2,
  output logic        core_rst_o,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW   = $clog2(BRAMWORDS) + 1;
  localparam int unsigned RunMax = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
  localparam int unsigned RunW   = $clog2(RunMax) + 1;
  localparam logic [CntW-1:0] LastWord = CntW'(BRAMWORDS - 1);
  localparam logic [RunW-1:0] RunLast  = RunW'(RUN_CYCLES - 1);
  localparam logic [RunW-1:0] RstLast  = RunW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StCoreRst, StRun, StDumpAddr, StDumpWait, StDumpPresent, StDone
  } state_e;

  state_e          state;
  logic [31:0]     addr;
  logic [CntW-1:0] count;
  logic [RunW-1:0] run_cnt;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state         <= StIdle;
      addr          <= '0;
      count         <= '0;
      run_cnt       <= '0;
      Debug_RAM_A2  <= '0;
      Debug_RAM_WD2 <= '0;
      Debug_RAM_WE2 <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      core_rst_o    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      Debug_RAM_WE2 <= 4'h0;
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state    <= StLoad;
            addr     <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        StLoad: begin
          if (in_valid && in_ready) begin
            Debug_RAM_A2  <= addr;
            Debug_RAM_WD2 <= in_data;
            Debug_RAM_WE2 <= 4'hF;
            addr          <= addr + 32'd4;
            count         <= count + 1'b1;
            // Final word either flagged by the host or filling the BRAM.
            if (in_last || count == LastWord) begin
              state    <= StCoreRst;
              in_ready <= 1'b0;
              run_cnt  <= '0;
            end
          end
        end
        StCoreRst: begin
          if (run_cnt == RstLast) begin
            state      <= StRun;
            core_rst_o <= 1'b0;
            run_cnt    <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        StRun: begin
          if (run_cnt == RunLast) begin
            state        <= StDumpAddr;
            core_rst_o   <= 1'b1;
            addr         <= '0;
            count        <= '0;
            Debug_RAM_A2 <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        // A2 was loaded on entry; the BRAM samples it at the end of this cycle.
        StDumpAddr: state <= StDumpWait;
        StDumpWait: begin
          out_data  <= Debug_RAM_RD2;
          out_valid <= 1'b1;
          out_last  <= (count == LastWord);
          state     <= StDumpPresent;
        end
        StDumpPresent: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              addr         <= addr + 32'd4;
              count        <= count + 1'b1;
              Debug_RAM_A2 <= addr + 32'd4;
              state        <= StDumpAddr;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
